// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the RV32 register-file sequencer.
//   XLEN                 : register / bus data width
//   NREGS                : number of register storage cells (power of two)
//   AW                   : register address width
//   reg_addr_t           : register index type
//   xword_t              : register data word type
//   regfile_ctrl_state_e : sequencer states (IDLE, READ, RESP, WRITE)
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xword_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      RESP  = 2'd2,
      WRITE = 2'd3
   } regfile_ctrl_state_e;

endpackage

// File: rtl/regfile_ctrl_decoder.sv
// ----------------------------------------------------------------------------
// onehot_decoder
// Turns a register index into a one-hot select vector, or all zeros when
// the enable is low.
//   i_en     : in,  1     - drive a select this cycle
//   i_addr   : in,  AW    - register index to select
//   o_onehot : out, NREGS - one-hot select (zero when i_en is low)
// ----------------------------------------------------------------------------
module onehot_decoder #(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             i_en,
   input  logic [AW-1:0]    i_addr,
   output logic [NREGS-1:0] o_onehot
);

   // Pure combinational decode; idle means every line is low so no
   // register drives its bus or latches data.
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_ctrl
// Sequencer in front of the per-register storage cells. One request carries
// two source reads and an optional destination write. Operands are read
// first and returned over the response handshake; the write happens only
// afterwards, so a read of the destination always sees the old value.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_rs1, req_rs2        : source register indices
//   req_rd, req_we          : destination index and write request
//   req_wdata               : data to write
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rs1_data/rs2_data   : returned operands
//   enable_a, enable_b      : one-hot read enables onto the shared buses
//   store                   : one-hot store strobe
//   wr_data                 : write-data bus to every register cell
//   a_bus, b_bus            : shared tristate read buses
// ----------------------------------------------------------------------------
module regfile_ctrl #(
   parameter int XLEN  = regfile_pkg::XLEN,
   parameter int NREGS = regfile_pkg::NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    req_rs1,
   input  logic [AW-1:0]    req_rs2,
   input  logic [AW-1:0]    req_rd,
   input  logic             req_we,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_rs1_data,
   output logic [XLEN-1:0]  rsp_rs2_data,
   output logic [NREGS-1:0] enable_a,
   output logic [NREGS-1:0] enable_b,
   output logic [NREGS-1:0] store,
   output logic [XLEN-1:0]  wr_data,
   input  logic [XLEN-1:0]  a_bus,
   input  logic [XLEN-1:0]  b_bus
);

   import regfile_pkg::*;

   regfile_ctrl_state_e r_state;
   logic [AW-1:0]       r_rs1;
   logic [AW-1:0]       r_rs2;
   logic [AW-1:0]       r_rd;
   logic                r_we;
   logic [XLEN-1:0]     r_wdata;
   logic [XLEN-1:0]     r_rs1Data;
   logic [XLEN-1:0]     r_rs2Data;
   logic                r_rspValid;

   logic                w_enA;
   logic                w_enB;
   logic                w_storeEn;

   // x0 is never put on a bus; its operand is substituted with zero when
   // the bus is captured. A reset arriving during WRITE also cancels the
   // strobe so the storage cell never commits an abandoned request.
   assign w_enA     = (r_state == READ) && (r_rs1 != '0);
   assign w_enB     = (r_state == READ) && (r_rs2 != '0);
   assign w_storeEn = (r_state == WRITE) && !reset;

   assign req_ready    = (r_state == IDLE);
   assign rsp_valid    = r_rspValid;
   assign rsp_rs1_data = r_rs1Data;
   assign rsp_rs2_data = r_rs2Data;
   assign wr_data      = w_storeEn ? r_wdata : '0;

   onehot_decoder #(.NREGS(NREGS), .AW(AW)) u_decA (
      .i_en     (w_enA),
      .i_addr   (r_rs1),
      .o_onehot (enable_a)
   );

   onehot_decoder #(.NREGS(NREGS), .AW(AW)) u_decB (
      .i_en     (w_enB),
      .i_addr   (r_rs2),
      .o_onehot (enable_b)
   );

   // The write path never shares a cycle with the reads, so the store
   // strobe can only appear after the response has been taken.
   onehot_decoder #(.NREGS(NREGS), .AW(AW)) u_decStore (
      .i_en     (w_storeEn),
      .i_addr   (r_rd),
      .o_onehot (store)
   );

   // Main sequencer: accept in IDLE, read for one cycle, hold the response
   // until it is taken, then optionally commit the write for one cycle.
   // Writes to x0 skip WRITE entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_rs1Data  <= '0;
         r_rs2Data  <= '0;
         r_rspValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_rs1   <= req_rs1;
                  r_rs2   <= req_rs2;
                  r_rd    <= req_rd;
                  r_we    <= req_we;
                  r_wdata <= req_wdata;
                  r_state <= READ;
               end
            end
            READ: begin
               r_rs1Data  <= (r_rs1 == '0) ? '0 : a_bus;
               r_rs2Data  <= (r_rs2 == '0) ? '0 : b_bus;
               r_rspValid <= 1'b1;
               r_state    <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= (r_we && (r_rd != '0)) ? WRITE : IDLE;
               end
            end
            WRITE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_ctrl
// Directed bench for regfile_ctrl with a simple storage-cell and bus model.
// ----------------------------------------------------------------------------
module tb_regfile_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [4:0]  req_rd;
   logic        req_we;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rs1_data;
   logic [31:0] rsp_rs2_data;
   logic [31:0] enable_a;
   logic [31:0] enable_b;
   logic [31:0] store;
   logic [31:0] wr_data;
   logic [31:0] a_bus;
   logic [31:0] b_bus;

   logic [31:0] cells [32];
   int nVectors = 0;
   int nMiscompares = 0;

   regfile_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_rd       (req_rd),
      .req_we       (req_we),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rs1_data (rsp_rs1_data),
      .rsp_rs2_data (rsp_rs2_data),
      .enable_a     (enable_a),
      .enable_b     (enable_b),
      .store        (store),
      .wr_data      (wr_data),
      .a_bus        (a_bus),
      .b_bus        (b_bus)
   );

   always #5 clk = ~clk;

   // Storage cells latch wr_data on their strobe; a bus with no driver
   // reads back as garbage so x0 substitution is actually exercised.
   always @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (store[i]) cells[i] <= wr_data;
      end
   end

   always_comb begin
      a_bus = 32'hBAADF00D;
      b_bus = 32'hBAADF00D;
      for (int i = 0; i < 32; i++) begin
         if (enable_a[i]) a_bus = cells[i];
         if (enable_b[i]) b_bus = cells[i];
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   // Waits (bounded) for req_ready, presents one request for one cycle and
   // returns at the falling edge of the READ cycle.
   task automatic sendReq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic we, input logic [31:0] wd);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      while (!req_ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      nVectors++; if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL req_ready_wait got %b want 1", req_ready); end
      req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_we = we; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_rs1 = 5'd31; req_rs2 = 5'd31; req_rd = 5'd31; req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      nVectors++; if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
      nVectors++; if (rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      nVectors++; if (enable_a !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_enable_a got %h want 0", enable_a); end
      nVectors++; if (enable_b !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_enable_b got %h want 0", enable_b); end
      nVectors++; if (store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_store got %h want 0", store); end
      nVectors++; if (wr_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_wr_data got %h want 0", wr_data); end
      nVectors++; if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_rsp_data got %h/%h want 0/0", rsp_rs1_data, rsp_rs2_data); end
   endtask

   task automatic test_write_only();
      rsp_ready = 1'b1;
      sendReq(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF);
      nVectors++; if (enable_a !== 32'h0 || enable_b !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wo_x0_enables got %h/%h want 0/0", enable_a, enable_b); end
      nVectors++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wo_read_ctl got rdy=%b vld=%b want 0/0", req_ready, rsp_valid); end
      @(negedge clk);
      nVectors++; if (rsp_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wo_rsp_valid got %b want 1", rsp_valid); end
      nVectors++; if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wo_x0_data got %h/%h want 0/0", rsp_rs1_data, rsp_rs2_data); end
      nVectors++; if (store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wo_resp_store got %h want 0", store); end
      @(negedge clk);
      nVectors++; if (store !== 32'h20) begin nMiscompares++; $display("[TB] FAIL wo_store got %h want 00000020", store); end
      nVectors++; if (wr_data !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL wo_wr_data got %h want deadbeef", wr_data); end
      nVectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wo_write_ctl got vld=%b rdy=%b want 0/0", rsp_valid, req_ready); end
      @(negedge clk);
      nVectors++; if (store !== 32'h0 || wr_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wo_after_write got %h/%h want 0/0", store, wr_data); end
      nVectors++; if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wo_ready_back got %b want 1", req_ready); end
   endtask

   task automatic test_read();
      rsp_ready = 1'b1;
      sendReq(5'd5, 5'd5, 5'd0, 1'b0, 32'h0);
      nVectors++; if (enable_a !== 32'h20 || enable_b !== 32'h20) begin nMiscompares++; $display("[TB] FAIL rd_enables got %h/%h want 20/20", enable_a, enable_b); end
      nVectors++; if (store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rd_store got %h want 0", store); end
      @(negedge clk);
      nVectors++; if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL rd_data got %h/%h want deadbeef/deadbeef", rsp_rs1_data, rsp_rs2_data); end
      nVectors++; if (enable_a !== 32'h0 || enable_b !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rd_resp_enables got %h/%h want 0/0", enable_a, enable_b); end
      @(negedge clk);
      nVectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rd_no_write got rdy=%b vld=%b store=%h want 1/0/0", req_ready, rsp_valid, store); end
   endtask

   task automatic test_read_overwrite();
      rsp_ready = 1'b1;
      sendReq(5'd0, 5'd0, 5'd7, 1'b1, 32'h11);
      repeat (3) @(negedge clk);
      sendReq(5'd7, 5'd5, 5'd7, 1'b1, 32'h22);
      nVectors++; if (enable_a !== 32'h80 || enable_b !== 32'h20) begin nMiscompares++; $display("[TB] FAIL ow_enables got %h/%h want 80/20", enable_a, enable_b); end
      @(negedge clk);
      nVectors++; if (rsp_rs1_data !== 32'h11 || rsp_rs2_data !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL ow_old_value got %h/%h want 11/deadbeef", rsp_rs1_data, rsp_rs2_data); end
      @(negedge clk);
      nVectors++; if (store !== 32'h80 || wr_data !== 32'h22) begin nMiscompares++; $display("[TB] FAIL ow_store got %h/%h want 80/22", store, wr_data); end
      @(negedge clk);
      sendReq(5'd7, 5'd0, 5'd0, 1'b0, 32'h0);
      @(negedge clk);
      nVectors++; if (rsp_rs1_data !== 32'h22 || rsp_rs2_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL ow_new_value got %h/%h want 22/0", rsp_rs1_data, rsp_rs2_data); end
      @(negedge clk);
   endtask

   task automatic test_backpressure_x0();
      rsp_ready = 1'b0;
      sendReq(5'd5, 5'd7, 5'd0, 1'b1, 32'h55);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         nVectors++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL bp_hold_ctl cyc %0d got vld=%b rdy=%b want 1/0", k, rsp_valid, req_ready); end
         nVectors++; if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h22) begin nMiscompares++; $display("[TB] FAIL bp_hold_data cyc %0d got %h/%h want deadbeef/22", k, rsp_rs1_data, rsp_rs2_data); end
         nVectors++; if (store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL bp_store cyc %0d got %h want 0", k, store); end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      nVectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL bp_x0_skip got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
      nVectors++; if (store !== 32'h0 || wr_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL bp_x0_store got %h/%h want 0/0", store, wr_data); end
   endtask

   task automatic test_reset_midop();
      rsp_ready = 1'b0;
      sendReq(5'd5, 5'd0, 5'd7, 1'b1, 32'h77);
      @(negedge clk);
      nVectors++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL rm_resp got vld=%b data=%h want 1/deadbeef", rsp_valid, rsp_rs1_data); end
      reset = 1'b1;
      @(negedge clk);
      nVectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rm_resp_idle got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
      nVectors++; if (rsp_rs1_data !== 32'h0 || store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rm_resp_clear got data=%h store=%h want 0/0", rsp_rs1_data, store); end
      reset = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      sendReq(5'd7, 5'd0, 5'd0, 1'b0, 32'h0);
      @(negedge clk);
      nVectors++; if (rsp_rs1_data !== 32'h22) begin nMiscompares++; $display("[TB] FAIL rm_x7_kept got %h want 22", rsp_rs1_data); end
      @(negedge clk);
      sendReq(5'd0, 5'd0, 5'd5, 1'b1, 32'h99);
      @(negedge clk);
      @(negedge clk);
      nVectors++; if (store !== 32'h20) begin nMiscompares++; $display("[TB] FAIL rm_in_write got %h want 20", store); end
      reset = 1'b1;
      #1;
      nVectors++; if (store !== 32'h0 || wr_data !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rm_write_cancel got %h/%h want 0/0", store, wr_data); end
      @(negedge clk);
      nVectors++; if (req_ready !== 1'b1 || store !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rm_write_idle got rdy=%b store=%h want 1/0", req_ready, store); end
      reset = 1'b0;
      @(negedge clk);
      sendReq(5'd5, 5'd0, 5'd0, 1'b0, 32'h0);
      @(negedge clk);
      nVectors++; if (rsp_rs1_data !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL rm_x5_kept got %h want deadbeef", rsp_rs1_data); end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) cells[i] = 32'h0;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0; req_we = 1'b0; req_wdata = 32'h0;
      test_reset();
      test_write_only();
      test_read();
      test_read_overwrite();
      test_backpressure_x0();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
